head_east_driver: RTL and testbench

- Transmit-side counterpart to the IMPACT head's 32-bit East input bus.
- Buffers 32-bit words pushed over a valid/ready interface in a small FIFO.
- Drives each word onto the East bus for a programmable hold time, followed by an optional idle gap.
- Sits between the control fabric and the head's East port, so stimulus can be streamed into the head at a controlled rate.

---
 rtl/head_east_driver.sv | 140 ++++++++++++++
 tb/tb_head_east_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/head_east_driver.sv
// Streams queued 32-bit words onto the IMPACT head East bus with a programmable hold time and idle gap.
// Optional feature macro: EAST_PARITY_EN adds the registered odd-parity output east_par.
module head_east_driver #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] IDLE_WORD = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     enable,
   input  logic                     flush,
   input  logic [7:0]               hold_cycles,
   input  logic [7:0]               gap_cycles,
   input  logic                     wr_valid,
   input  logic [31:0]              wr_data,
   output logic                     wr_ready,
   output logic [31:0]              east_o,
   output logic                     east_strobe,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         words_sent
`ifdef EAST_PARITY_EN
   ,
   output logic                     east_par
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   state_t        state, state_n;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count;
   logic [7:0]    hold_cnt, hold_cnt_n;
   logic [7:0]    gap_lat, gap_lat_n;
   logic [7:0]    gap_cnt, gap_cnt_n;
   logic [31:0]   east_n;
   logic          full, empty, push, pop, launch_ok, try_launch;

   assign full       = (count == LW'(DEPTH));
   assign empty      = (count == '0);
   assign wr_ready   = !full && !flush;
   assign push       = wr_valid && wr_ready;
   assign launch_ok  = enable && !empty && !flush;
   assign fifo_level = count;

   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Flush clears the queue but leaves the word already on the bus alone.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(push) - LW'(pop);
      end
   end

   always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      gap_lat_n  = gap_lat;
      gap_cnt_n  = gap_cnt;
      east_n     = east_o;
      pop        = 1'b0;
      try_launch = 1'b0;
      case (state)
         IDLE: try_launch = 1'b1;
         HOLD: begin
            if (hold_cnt != 8'd0) begin
               hold_cnt_n = hold_cnt - 8'd1;
            end else if (gap_lat != 8'd0) begin
               state_n   = GAP;
               gap_cnt_n = gap_lat;
               east_n    = IDLE_WORD;
            end else begin
               try_launch = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt > 8'd1) gap_cnt_n = gap_cnt - 8'd1;
            else                try_launch = 1'b1;
         end
         default: try_launch = 1'b1;
      endcase
      // Every end-of-word/gap path funnels through the same launch check, so back-to-back words share one code path.
      if (try_launch) begin
         state_n = IDLE;
         east_n  = IDLE_WORD;
         if (launch_ok) begin
            pop        = 1'b1;
            state_n    = HOLD;
            east_n     = mem[rd_ptr];
            hold_cnt_n = hold_cycles;
            gap_lat_n  = gap_cycles;
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         gap_lat     <= '0;
         gap_cnt     <= '0;
         east_o      <= IDLE_WORD;
         east_strobe <= 1'b0;
         busy        <= 1'b0;
         words_sent  <= '0;
`ifdef EAST_PARITY_EN
         east_par    <= ~^IDLE_WORD;
`endif
      end else begin
         state       <= state_n;
         hold_cnt    <= hold_cnt_n;
         gap_lat     <= gap_lat_n;
         gap_cnt     <= gap_cnt_n;
         east_o      <= east_n;
         east_strobe <= pop;
         busy        <= (state_n != IDLE);
         words_sent  <= words_sent + CNT_W'(pop);
`ifdef EAST_PARITY_EN
         east_par    <= ~^east_n;
`endif
      end
   end

endmodule

// File: tb/tb_head_east_driver.sv
// Self-checking bench for head_east_driver: directed vector table, a mid-hold async reset, and random traffic
// checked against a launch-schedule model of the bus timing.
module tb_head_east_driver;

   localparam int          DEPTH     = 8;
   localparam logic [31:0] IDLE_WORD = 32'h0000_0000;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        enable = 1'b0, flush = 1'b0, wr_valid = 1'b0;
   logic [7:0]  hold_cycles = 8'd0, gap_cycles = 8'd0;
   logic [31:0] wr_data = 32'd0;
   logic        wr_ready, east_strobe, busy;
   logic [31:0] east_o;
   logic [3:0]  fifo_level;
   logic [15:0] words_sent;
`ifdef EAST_PARITY_EN
   logic        east_par;
`endif

   int checks = 0;
   int errors = 0;

   head_east_driver #(.DEPTH(DEPTH), .IDLE_WORD(IDLE_WORD), .CNT_W(16)) dut (
      .wb_clk_i(wb_clk_i),
      .wb_rst_i(wb_rst_i),
      .enable(enable),
      .flush(flush),
      .hold_cycles(hold_cycles),
      .gap_cycles(gap_cycles),
      .wr_valid(wr_valid),
      .wr_data(wr_data),
      .wr_ready(wr_ready),
      .east_o(east_o),
      .east_strobe(east_strobe),
      .busy(busy),
      .fifo_level(fifo_level),
      .words_sent(words_sent)
`ifdef EAST_PARITY_EN
      ,
      .east_par(east_par)
`endif
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic        en;
      logic        fl;
      logic [7:0]  h;
      logic [7:0]  g;
      logic        wv;
      logic [31:0] wd;
      logic [31:0] xe;
      logic        xs;
      logic        xb;
      logic [3:0]  xl;
   } vec_t;

   vec_t vecs[$];

   // Model: a launch may happen at edge k once k >= free_at; a word launched at k with hold h and gap g
   // is on the bus for edges k..k+h and frees the bus for the next launch at k+h+1+g.
   logic [31:0] mq[$];
   int          edge_idx = 0;
   int          free_at = 0;
   int          word_until = -1;
   int          sent = 0;
   logic [31:0] cur_word = IDLE_WORD;
   logic [31:0] exp_east = IDLE_WORD;
   logic        exp_strobe = 1'b0, exp_busy = 1'b0;
   int          exp_level = 0;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      free_at    = 0;
      word_until = -1;
      sent       = 0;
      cur_word   = IDLE_WORD;
      exp_east   = IDLE_WORD;
      exp_strobe = 1'b0;
      exp_busy   = 1'b0;
      exp_level  = 0;
   endtask

   task automatic checkOutput();
      compare("east_o", east_o, exp_east);
      compare("east_strobe", 32'(east_strobe), 32'(exp_strobe));
      compare("busy", 32'(busy), 32'(exp_busy));
      compare("fifo_level", 32'(fifo_level), 32'(exp_level));
      compare("words_sent", 32'(words_sent), 32'(16'(sent)));
`ifdef EAST_PARITY_EN
      compare("east_par", 32'(east_par), 32'(~^exp_east));
`endif
   endtask

   task automatic applyStimulus(input logic en, input logic fl, input logic [7:0] h, input logic [7:0] g,
                                input logic wv, input logic [31:0] wd);
      logic ready;
      logic launched;
      enable      = en;
      flush       = fl;
      hold_cycles = h;
      gap_cycles  = g;
      wr_valid    = wv;
      wr_data     = wd;
      #1;
      ready = !fl && (mq.size() < DEPTH);
      compare("wr_ready", 32'(wr_ready), 32'(ready));
      edge_idx++;
      launched = 1'b0;
      if (fl) begin
         mq.delete();
      end else if (en && mq.size() > 0 && edge_idx >= free_at) begin
         cur_word   = mq.pop_front();
         launched   = 1'b1;
         word_until = edge_idx + int'(h);
         free_at    = edge_idx + int'(h) + 1 + int'(g);
         sent++;
      end
      if (wv && ready) mq.push_back(wd);
      exp_east   = (edge_idx <= word_until) ? cur_word : IDLE_WORD;
      exp_strobe = launched;
      exp_busy   = (edge_idx < free_at);
      exp_level  = mq.size();
      @(posedge wb_clk_i);
      #1;
      checkOutput();
   endtask

   function automatic vec_t mk(input logic en, input logic fl, input logic [7:0] h, input logic [7:0] g,
                               input logic wv, input logic [31:0] wd, input logic [31:0] xe,
                               input logic xs, input logic xb, input logic [3:0] xl);
      vec_t v;
      v.en = en; v.fl = fl; v.h = h; v.g = g; v.wv = wv; v.wd = wd;
      v.xe = xe; v.xs = xs; v.xb = xb; v.xl = xl;
      return v;
   endfunction

   initial begin
      // Single word, hold 3 cycles, no gap.
      vecs.push_back(mk(1'b1, 1'b0, 8'd2, 8'd0, 1'b1, 32'hDEAD_BEEF, IDLE_WORD,     1'b0, 1'b0, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 32'h0,        IDLE_WORD,     1'b0, 1'b0, 4'd0));
      // A, B, C back-to-back with one-cycle hold.
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 32'hAAAA_0001, IDLE_WORD,     1'b0, 1'b0, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 32'hAAAA_0002, 32'hAAAA_0001, 1'b1, 1'b1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 32'hAAAA_0003, 32'hAAAA_0002, 1'b1, 1'b1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0,         32'hAAAA_0003, 1'b1, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0,         IDLE_WORD,     1'b0, 1'b0, 4'd0));
      // Fill to DEPTH with enable low, ninth push refused, then drain in order.
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 32'(32'h1000_0000 + i), IDLE_WORD, 1'b0, 1'b0, 4'(i + 1)));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 32'h1111_1111, IDLE_WORD, 1'b0, 1'b0, 4'd8));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0, 32'(32'h1000_0000 + i), 1'b1, 1'b1, 4'(7 - i)));
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0, IDLE_WORD, 1'b0, 1'b0, 4'd0));
      // Hold 2 + gap 3 for W0; config changed during W0 only shapes W1.
      vecs.push_back(mk(1'b0, 1'b0, 8'd1, 8'd3, 1'b1, 32'h4000_0000, IDLE_WORD,     1'b0, 1'b0, 4'd1));
      vecs.push_back(mk(1'b0, 1'b0, 8'd1, 8'd3, 1'b1, 32'h4000_0001, IDLE_WORD,     1'b0, 1'b0, 4'd2));
      vecs.push_back(mk(1'b1, 1'b0, 8'd1, 8'd3, 1'b0, 32'h0,         32'h4000_0000, 1'b1, 1'b1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0,         32'h4000_0000, 1'b0, 1'b1, 4'd1));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0, IDLE_WORD, 1'b0, 1'b1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0, 32'h4000_0001, 1'b1, 1'b1, 4'd0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0, 32'h4000_0001, 1'b0, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0, IDLE_WORD, 1'b0, 1'b0, 4'd0));
      // Flush during HOLD of W0 with four words behind it; the flush-cycle push is dropped.
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1'b0, 1'b0, 8'd3, 8'd0, 1'b1, 32'(32'h5000_0000 + i), IDLE_WORD, 1'b0, 1'b0, 4'(i + 1)));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0,         32'h5000_0000, 1'b1, 1'b1, 4'd4));
      vecs.push_back(mk(1'b1, 1'b1, 8'd3, 8'd0, 1'b1, 32'hBAD0_BAD0, 32'h5000_0000, 1'b0, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0,         32'h5000_0000, 1'b0, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0,         32'h5000_0000, 1'b0, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0,         IDLE_WORD,     1'b0, 1'b0, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'h0,         IDLE_WORD,     1'b0, 1'b0, 4'd0));
      // Odd-weight word, parity bit expected low.
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 32'h0000_0001, IDLE_WORD,     1'b0, 1'b0, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0,         32'h0000_0001, 1'b1, 1'b1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0,         IDLE_WORD,     1'b0, 1'b0, 4'd0));

      modelReset();
      repeat (2) @(posedge wb_clk_i);
      #1;
      checkOutput();
      wb_rst_i = 1'b0;
      #1;
      compare("wr_ready_after_reset", 32'(wr_ready), 32'd1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].fl, vecs[i].h, vecs[i].g, vecs[i].wv, vecs[i].wd);
         compare($sformatf("tbl%0d_east", i), east_o, vecs[i].xe);
         compare($sformatf("tbl%0d_strobe", i), 32'(east_strobe), 32'(vecs[i].xs));
         compare($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].xb));
         compare($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(vecs[i].xl));
      end

      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(9) != 0, $urandom_range(39) == 0, 8'($urandom_range(3)),
                       8'($urandom_range(2)), 1'($urandom_range(1)), $urandom);
      end

      // Drain, then hit an asynchronous reset partway through a long hold.
      for (int i = 0; i < 60; i++)
         applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 8'd20, 8'd0, 1'b1, 32'hC0DE_0001);
      applyStimulus(1'b1, 1'b0, 8'd20, 8'd0, 1'b1, 32'hC0DE_0002);
      applyStimulus(1'b1, 1'b0, 8'd20, 8'd0, 1'b0, 32'h0);
      compare("busy_before_reset", 32'(busy), 32'd1);
      #2;
      wb_rst_i = 1'b1;
      #1;
      compare("async_rst_east", east_o, IDLE_WORD);
      compare("async_rst_busy", 32'(busy), 32'd0);
      compare("async_rst_sent", 32'(words_sent), 32'd0);
      compare("async_rst_level", 32'(fifo_level), 32'd0);
      compare("async_rst_strobe", 32'(east_strobe), 32'd0);
`ifdef EAST_PARITY_EN
      compare("async_rst_par", 32'(east_par), 32'd1);
`endif
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      modelReset();
      checkOutput();
      applyStimulus(1'b1, 1'b0, 8'd1, 8'd1, 1'b1, 32'h7777_0001);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
